if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC and issues single-outstanding fetch requests to instruction memory. It delivers `instr_r` / `pc_plus_1_if_r` to the decode stage and applies the jump/branch targets that decode computes. It honours the MIPS one-instruction delay slot, holds its output under stall, and squashes wrong-path fetches.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/if_skid_buf.sv | 31 +++
 rtl/if_stage.sv | 171 +++++++++++++++++
 tb/tb_if_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline: fetch FSM encoding, NOP word, default reset PC.
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } if_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] next_word(input logic [31:0] addr);
      return addr + 32'd4;
   endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry parking slot for a fetch response that arrives while decode is stalled.
module if_skid_buf
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  logic        inval,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc,
   output logic        valid,
   output logic [31:0] instr,
   output logic [31:0] fetch_pc
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         valid    <= 1'b0;
         instr    <= NOP_INSTR;
         fetch_pc <= '0;
      end else if (inval) begin
         valid <= 1'b0;
      end else if (load) begin
         valid    <= 1'b1;
         instr    <= load_instr;
         fetch_pc <= load_pc;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, single-outstanding imem requests, delay-slot aware redirect.
// Optional IF_PERF_CNT_EN adds delivered-instruction and stall-cycle counters.
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall_if,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   output logic [31:0] instr_r,
   output logic [31:0] pc_plus_1_if_r,
   output logic        instr_valid_if_r
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   if_state_t   state;
   logic [31:0] pc, fetch_pc, redir_pc;
   logic        redir_pend, squash;

   logic        sk_valid;
   logic [31:0] sk_instr, sk_pc;

   logic        redir_early, redir_late, gnt_fire, resp_bad, hold_bad;
   logic        deliver, sk_load, sk_clear, sk_inval;
   logic [31:0] dlv_instr, dlv_pc;

   // pc == pc_plus_1_if_r means the delay slot has not been granted yet
   always_comb begin
      redir_early = redirect && (pc == pc_plus_1_if_r);
      redir_late  = redirect && (pc != pc_plus_1_if_r);
      imem_req    = !rst && ((state == FETCH) ||
                    (state == WAIT && imem_rvalid && !stall_if && !squash));
      imem_addr   = pc;
      gnt_fire    = imem_req && imem_gnt;
      resp_bad    = squash || (redir_late && (fetch_pc != pc_plus_1_if_r));
      hold_bad    = redir_late && (sk_pc != pc_plus_1_if_r);
      deliver     = 1'b0;
      dlv_instr   = imem_rdata;
      dlv_pc      = fetch_pc;
      sk_load     = 1'b0;
      sk_clear    = 1'b0;
      sk_inval    = 1'b0;
      case (state)
         WAIT: begin
            if (imem_rvalid && !resp_bad) begin
               if (stall_if) sk_load = 1'b1;
               else          deliver = 1'b1;
            end
         end
         HOLD: begin
            if (hold_bad) begin
               sk_inval = 1'b1;
            end else if (!stall_if && sk_valid) begin
               deliver   = 1'b1;
               dlv_instr = sk_instr;
               dlv_pc    = sk_pc;
               sk_clear  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         fetch_pc   <= RESET_PC;
         redir_pc   <= RESET_PC;
         redir_pend <= 1'b0;
         squash     <= 1'b0;
      end else begin
         if (redir_late)
            pc <= redirect_addr;
         else if (gnt_fire)
            pc <= redir_early ? redirect_addr : (redir_pend ? redir_pc : next_word(pc));

         if (gnt_fire) begin
            fetch_pc   <= pc;
            redir_pend <= 1'b0;
         end else if (redir_early) begin
            redir_pend <= 1'b1;
            redir_pc   <= redirect_addr;
         end

         // a grant in a late-redirect cycle fetched the old path, so it is squashed
         case (state)
            FETCH: begin
               if (gnt_fire) begin
                  state  <= WAIT;
                  squash <= redir_late;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  if (gnt_fire) begin
                     state  <= WAIT;
                     squash <= redir_late;
                  end else if (!resp_bad && stall_if) begin
                     state <= HOLD;
                  end else begin
                     state  <= FETCH;
                     squash <= 1'b0;
                  end
               end else if (redir_late && (fetch_pc != pc_plus_1_if_r)) begin
                  squash <= 1'b1;
               end
            end
            HOLD: begin
               if (hold_bad || !stall_if || !sk_valid) state <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_r          <= NOP_INSTR;
         pc_plus_1_if_r   <= RESET_PC;
         instr_valid_if_r <= 1'b0;
      end else if (!stall_if) begin
         if (deliver) begin
            instr_r          <= dlv_instr;
            pc_plus_1_if_r   <= next_word(dlv_pc);
            instr_valid_if_r <= 1'b1;
         end else begin
            instr_r          <= NOP_INSTR;
            instr_valid_if_r <= 1'b0;
         end
      end
   end

   if_skid_buf u_skid (
      .clk        (clk),
      .rst        (rst),
      .load       (sk_load),
      .clear      (sk_clear),
      .inval      (sk_inval),
      .load_instr (imem_rdata),
      .load_pc    (fetch_pc),
      .valid      (sk_valid),
      .instr      (sk_instr),
      .fetch_pc   (sk_pc)
   );

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (deliver)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (stall_if) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: memory model plus program-order stream and fetch-path models.
module tb_if_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] KEY    = 32'h5A5A_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req, imem_gnt, imem_rvalid, stall_if, redirect;
   logic [31:0] imem_addr, imem_rdata, redirect_addr;
   logic [31:0] instr_r, pc_plus_1_if_r;
   logic        instr_valid_if_r;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(RST_PC)) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_gnt         (imem_gnt),
      .imem_rvalid      (imem_rvalid),
      .imem_rdata       (imem_rdata),
      .stall_if         (stall_if),
      .redirect         (redirect),
      .redirect_addr    (redirect_addr),
      .instr_r          (instr_r),
      .pc_plus_1_if_r   (pc_plus_1_if_r),
      .instr_valid_if_r (instr_valid_if_r)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt   (perf_fetch_cnt),
      .perf_stall_cnt   (perf_stall_cnt)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        memq[$];
   int          checks = 0, errors = 0;
   int          cyc = 0, lat = 1, gnt_pct = 100, stall_pct = 0, redir_pct = 0;
   // program-order model: next address decode must receive
   logic [31:0] exp_next = RST_PC, s_target = '0;
   bit          s_pend = 0, cur_delay = 0;
   // fetch-path model: next address memory must be asked for
   logic [31:0] exp_fetch = RST_PC, f_target = '0;
   bit          f_pend = 0;
   bit          rst_prev = 1, stall_prev = 0, first_req_chk = 0;
   logic [31:0] prev_instr = '0, prev_p1 = RST_PC;
   logic        prev_valid = 1'b0;
   int          idle = 0, ndeliv = 0, nstall = 0, since_rst = 0, total_deliv = 0;
   int          nglog = 0, ndlog = 0, first_valid_at = -1;
   logic [31:0] glog[3], dlog_p1[3], dlog_instr[3];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ KEY;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      memq.delete();
      exp_next  = RST_PC;
      exp_fetch = RST_PC;
      s_pend    = 0;
      f_pend    = 0;
      cur_delay = 0;
      idle      = 0;
      ndeliv    = 0;
      nstall    = 0;
      since_rst = -1;
   endtask

   task automatic step(input bit do_rst);
      bit          late;
      logic [31:0] d;
      @(negedge clk);
      if (rst_prev) begin
         check32("rst_instr", instr_r, 32'h0);
         check32("rst_valid", {31'b0, instr_valid_if_r}, 32'h0);
         check32("rst_p1", pc_plus_1_if_r, RST_PC);
      end else if (stall_prev) begin
         check32("hold_instr", instr_r, prev_instr);
         check32("hold_p1", pc_plus_1_if_r, prev_p1);
         check32("hold_valid", {31'b0, instr_valid_if_r}, {31'b0, prev_valid});
         idle++;
      end else if (instr_valid_if_r) begin
         check32("deliver_p1", pc_plus_1_if_r, exp_next + 32'd4);
         check32("deliver_instr", instr_r, mem_word(exp_next));
         if (ndeliv == 0 && first_valid_at < 0) first_valid_at = since_rst;
         if (ndlog < 3) begin
            dlog_p1[ndlog]    = pc_plus_1_if_r;
            dlog_instr[ndlog] = instr_r;
            ndlog++;
         end
         if (s_pend) begin
            exp_next  = s_target;
            s_pend    = 0;
            cur_delay = 1;
         end else begin
            exp_next  = exp_next + 32'd4;
            cur_delay = 0;
         end
         ndeliv++;
         total_deliv++;
         idle = 0;
      end else begin
         check32("bubble_instr", instr_r, 32'h0);
         check32("bubble_p1", pc_plus_1_if_r, prev_p1);
         idle++;
      end
`ifdef IF_PERF_CNT_EN
      check32("perf_fetch", perf_fetch_cnt, ndeliv);
      check32("perf_stall", perf_stall_cnt, nstall);
`endif
      if (idle > 400) begin
         checks++;
         errors++;
         $display("FAIL liveness: got %0d idle cycles, required at most 400", idle);
         idle = 0;
      end
      prev_instr = instr_r;
      prev_p1    = pc_plus_1_if_r;
      prev_valid = instr_valid_if_r;

      rst           = do_rst;
      redirect      = 1'b0;
      redirect_addr = $urandom & 32'hFFFF_FFFC;
      if (do_rst) begin
         model_reset();
         first_req_chk = 1;
         stall_if      = 1'b0;
         imem_gnt      = 1'b0;
         imem_rvalid   = 1'b0;
         imem_rdata    = '0;
      end else begin
         imem_rvalid = (memq.size() > 0) && (memq[0].due <= cyc);
         imem_rdata  = imem_rvalid ? mem_word(memq[0].addr) : $urandom;
         imem_gnt    = int'($urandom_range(99)) < gnt_pct;
         stall_if    = int'($urandom_range(99)) < stall_pct;
         if (instr_valid_if_r && !s_pend && !cur_delay && !rst_prev &&
             int'($urandom_range(99)) < redir_pct) begin
            redirect      = 1'b1;
            redirect_addr = ($urandom_range(7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_3FFC);
            s_pend        = 1;
            s_target      = redirect_addr;
         end
      end
      #1;
      if (!do_rst) begin
         if (first_req_chk) begin
            check32("first_req", {31'b0, imem_req}, 32'h1);
            check32("first_addr", imem_addr, RST_PC);
            first_req_chk = 0;
         end
         late = 0;
         d    = pc_plus_1_if_r;
         if (redirect) begin
            if (exp_fetch == d) begin
               f_pend   = 1;
               f_target = redirect_addr;
            end else begin
               late = 1;
            end
         end
         if (imem_req && imem_gnt) begin
            check32("fetch_addr", imem_addr, exp_fetch);
            if (nglog < 3) begin
               glog[nglog] = imem_addr;
               nglog++;
            end
            exp_fetch = exp_fetch + 32'd4;
            if (f_pend) begin
               exp_fetch = f_target;
               f_pend    = 0;
            end
            memq.push_back('{addr: imem_addr, due: cyc + lat});
         end
         if (late) exp_fetch = redirect_addr;
         if (imem_rvalid) void'(memq.pop_front());
         if (memq.size() > 1) begin
            checks++;
            errors++;
            $display("FAIL outstanding: got %0d requests in flight, required at most 1", memq.size());
            memq.delete();
         end
         if (stall_if) nstall++;
      end
      rst_prev   = do_rst;
      stall_prev = !do_rst && stall_if;
      cyc++;
      since_rst++;
   endtask

   task automatic phase(input int l, input int g, input int s, input int r, input int n);
      lat = l; gnt_pct = g; stall_pct = s; redir_pct = r;
      for (int i = 0; i < n; i++) step(0);
   endtask

   initial begin
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
      stall_if = 0; redirect = 0; redirect_addr = '0;
      step(1);
      step(1);
      phase(1, 100, 0, 0, 12);
      check32("lit_grant0", glog[0], 32'h0);
      check32("lit_grant1", glog[1], 32'h4);
      check32("lit_grant2", glog[2], 32'h8);
      check32("lit_p1_0", dlog_p1[0], 32'h4);
      check32("lit_p1_1", dlog_p1[1], 32'h8);
      check32("lit_p1_2", dlog_p1[2], 32'hC);
      check32("lit_instr1", dlog_instr[1], 32'h5A5A_0004);
      check32("lit_first_valid", first_valid_at, 32'd2);
      phase(1, 100, 100, 0, 3);
      phase(1, 100, 0, 0, 6);
      phase(1, 100, 20, 10, 1500);
      phase(2, 33, 10, 10, 1500);
      phase(3, 60, 25, 15, 1500);
      phase(1, 50, 40, 20, 1500);
      phase(3, 100, 0, 15, 1500);
      lat = 3; gnt_pct = 100; stall_pct = 0; redir_pct = 0;
      for (int i = 0; i < 50 && memq.size() == 0; i++) step(0);
      step(1);
      phase(2, 80, 20, 15, 1500);
      checks++;
      if (total_deliv < 1000) begin
         errors++;
         $display("FAIL throughput: got %0d deliveries, required at least 1000", total_deliv);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
